// File: rtl/fetch_issue.sv
// Fetch/issue stage: PC register, BOOT/RUN/WAIT control and the
// instruction-memory request handshake.
module fetch_issue #(
  parameter int                      ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    next_PC_select,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  input  logic                    i_mem_ready,
  output logic                    i_mem_read,
  output logic [ADDRESS_BITS-1:0] i_mem_read_address,
  output logic [ADDRESS_BITS-1:0] issue_PC,
  output logic                    issue_valid,
  output logic [31:0]             fetch_count
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDRESS_BITS-1:0] pc_q;
  logic                    accept;
  logic                    miss;

  assign i_mem_read = (state_q != BOOT)
                    && !stall && !next_PC_select;
  assign accept     = i_mem_read && i_mem_ready;
  assign miss       = i_mem_read && !i_mem_ready;

  assign i_mem_read_address = pc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Stall holds the state, except that BOOT always lasts one cycle.
  always_comb begin
    state_d = state_q;
    if (next_PC_select)     state_d = RUN;
    else if (accept)        state_d = RUN;
    else if (miss)          state_d = WAIT;
    else if (state_q == BOOT) state_d = RUN;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      issue_PC    <= RESET_PC;
      issue_valid <= 1'b0;
      fetch_count <= '0;
    end else if (next_PC_select) begin
      pc_q        <= {target_PC[ADDRESS_BITS-1:2], 2'b00};
      issue_valid <= 1'b0;
    end else if (accept) begin
      issue_PC    <= pc_q;
      issue_valid <= 1'b1;
      pc_q        <= pc_q + ADDRESS_BITS'(4);
      if (fetch_count != 32'hFFFF_FFFF)
        fetch_count <= fetch_count + 32'd1;
    end else begin
      issue_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_issue.sv
// Directed bench for fetch_issue: vector table plus wrap and
// asynchronous-reset sequences.
module tb_fetch_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        next_PC_select;
  logic [31:0] target_PC;
  logic        i_mem_ready;

  logic        i_mem_read;
  logic [31:0] i_mem_read_address;
  logic [31:0] issue_PC;
  logic        issue_valid;
  logic [31:0] fetch_count;

  logic        w_read;
  logic [31:0] w_addr;
  logic [31:0] w_issue;
  logic        w_valid;
  logic [31:0] w_count;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fetch_issue #(.ADDRESS_BITS(32), .RESET_PC(32'h0)) dut (
    .clock              (clock),
    .reset              (reset),
    .stall              (stall),
    .next_PC_select     (next_PC_select),
    .target_PC          (target_PC),
    .i_mem_ready        (i_mem_ready),
    .i_mem_read         (i_mem_read),
    .i_mem_read_address (i_mem_read_address),
    .issue_PC           (issue_PC),
    .issue_valid        (issue_valid),
    .fetch_count        (fetch_count)
  );

  fetch_issue #(.ADDRESS_BITS(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock              (clock),
    .reset              (reset),
    .stall              (stall),
    .next_PC_select     (next_PC_select),
    .target_PC          (target_PC),
    .i_mem_ready        (i_mem_ready),
    .i_mem_read         (w_read),
    .i_mem_read_address (w_addr),
    .issue_PC           (w_issue),
    .issue_valid        (w_valid),
    .fetch_count        (w_count)
  );

  typedef struct {
    logic        stall;
    logic        sel;
    logic [31:0] target;
    logic        ready;
    logic        read;
    logic [31:0] addr;
    logic [31:0] issue;
    logic        valid;
    logic [31:0] count;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // stall sel target ready | read addr | issue valid count
    vecs[0]  = '{0, 0, 32'h0,   1, 0, 32'h000, 32'h000, 0, 0};
    vecs[1]  = '{0, 0, 32'h0,   1, 1, 32'h000, 32'h000, 1, 1};
    vecs[2]  = '{0, 0, 32'h0,   1, 1, 32'h004, 32'h004, 1, 2};
    vecs[3]  = '{0, 0, 32'h0,   0, 1, 32'h008, 32'h004, 0, 2};
    vecs[4]  = '{0, 0, 32'h0,   0, 1, 32'h008, 32'h004, 0, 2};
    vecs[5]  = '{0, 0, 32'h0,   0, 1, 32'h008, 32'h004, 0, 2};
    vecs[6]  = '{0, 0, 32'h0,   1, 1, 32'h008, 32'h008, 1, 3};
    vecs[7]  = '{0, 1, 32'h103, 1, 0, 32'h00C, 32'h008, 0, 3};
    vecs[8]  = '{0, 0, 32'h0,   1, 1, 32'h100, 32'h100, 1, 4};
    vecs[9]  = '{1, 1, 32'h200, 1, 0, 32'h104, 32'h100, 0, 4};
    vecs[10] = '{1, 0, 32'h0,   1, 0, 32'h200, 32'h100, 0, 4};
    vecs[11] = '{0, 0, 32'h0,   1, 1, 32'h200, 32'h200, 1, 5};
    vecs[12] = '{0, 0, 32'h0,   0, 1, 32'h204, 32'h200, 0, 5};
    vecs[13] = '{0, 1, 32'h31,  0, 0, 32'h204, 32'h200, 0, 5};
    vecs[14] = '{0, 0, 32'h0,   1, 1, 32'h030, 32'h030, 1, 6};
    vecs[15] = '{1, 0, 32'h0,   1, 0, 32'h034, 32'h030, 0, 6};

    reset          = 1'b1;
    stall          = 1'b0;
    next_PC_select = 1'b0;
    target_PC      = '0;
    i_mem_ready    = 1'b0;
    #12;
    chk("rst_read",  32'(i_mem_read), 32'h0);
    chk("rst_addr",  i_mem_read_address, 32'h0);
    chk("rst_issue", issue_PC, 32'h0);
    chk("rst_valid", 32'(issue_valid), 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      stall          = vecs[i].stall;
      next_PC_select = vecs[i].sel;
      target_PC      = vecs[i].target;
      i_mem_ready    = vecs[i].ready;
      #1;
      chk($sformatf("v%0d_read", i), 32'(i_mem_read),
          32'(vecs[i].read));
      chk($sformatf("v%0d_addr", i), i_mem_read_address,
          vecs[i].addr);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_issue", i), issue_PC, vecs[i].issue);
      chk($sformatf("v%0d_valid", i), 32'(issue_valid),
          32'(vecs[i].valid));
      chk($sformatf("v%0d_count", i), fetch_count, vecs[i].count);
    end

    // Address wrap from the top of the address space.
    stall          = 1'b0;
    next_PC_select = 1'b0;
    i_mem_ready    = 1'b1;
    reset          = 1'b1;
    #1;
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap_rst_issue", w_issue, 32'hFFFF_FFFC);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("wrap_read", 32'(w_read), 32'h1);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    @(posedge clock);
    #1;
    chk("wrap_addr1", w_addr, 32'h0);
    chk("wrap_issue", w_issue, 32'hFFFF_FFFC);
    chk("wrap_valid", 32'(w_valid), 32'h1);
    @(posedge clock);
    #1;
    chk("wrap_addr2", w_addr, 32'h4);
    chk("pre_count", fetch_count, 32'h2);

    // Asynchronous reset in the middle of a WAIT cycle.
    i_mem_ready = 1'b0;
    @(posedge clock);
    #1;
    chk("wait_addr", i_mem_read_address, 32'h8);
    chk("wait_read", 32'(i_mem_read), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_read",  32'(i_mem_read), 32'h0);
    chk("arst_addr",  i_mem_read_address, 32'h0);
    chk("arst_issue", issue_PC, 32'h0);
    chk("arst_valid", 32'(issue_valid), 32'h0);
    chk("arst_count", fetch_count, 32'h0);
    @(posedge clock);
    #1;
    chk("arst_hold_count", fetch_count, 32'h0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_issue.md
FETCH_ISSUE -- requirements
Module: fetch_issue

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 32, width of all PC/address signals.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset (bits [1:0] zero).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold PC, issue no request.
REQ-006 SHALL have port next_PC_select  input  1  1 = redirect fetch to target_PC.
REQ-007 SHALL have port target_PC  input  ADDRESS_BITS  redirect address.
REQ-008 SHALL have port i_mem_ready  input  1  instruction memory accepts the request this cycle.
REQ-009 SHALL have port i_mem_read  output  1  read request valid.
REQ-010 SHALL have port i_mem_read_address  output  ADDRESS_BITS  read address; equals PC register.
REQ-011 SHALL have port issue_PC  output  ADDRESS_BITS  PC of the request accepted on the previous edge; pairs with returning i_mem_data at the receive stage.
REQ-012 SHALL have port issue_valid  output  1  1 = issue_PC/returned data is a live instruction; 0 = receive stage must substitute NOP.
REQ-013 SHALL have port fetch_count  output  32  count of live (non-squashed) accepted fetches.

Function
REQ-014 SHALL hold a PC register and a state machine with states BOOT, RUN, WAIT.
REQ-015 SHALL drive i_mem_read = 1 only in RUN or WAIT with stall = 0 and next_PC_select = 0.
REQ-016 SHALL treat a request as accepted on an edge where i_mem_read = 1 and i_mem_ready = 1.
REQ-017 On acceptance SHALL load issue_PC <= PC, issue_valid <= 1, PC <= PC + 4 (modulo 2^ADDRESS_BITS, wrap to 0), state <= RUN.
REQ-018 On any edge with next_PC_select = 1 SHALL load PC <= {target_PC[ADDRESS_BITS-1:2], 2'b00}, issue_valid <= 0, state <= RUN; redirect has priority over stall, i_mem_ready and WAIT.
REQ-019 SHALL, when i_mem_read = 1 and i_mem_ready = 0, keep PC and i_mem_read_address unchanged, set issue_valid <= 0, and enter WAIT; WAIT returns to RUN on acceptance or redirect.
REQ-020 SHALL, with stall = 1 and next_PC_select = 0, keep PC and state unchanged and set issue_valid <= 0.
REQ-021 SHALL leave issue_PC unchanged on every edge without acceptance.
REQ-022 BOOT SHALL last exactly one cycle after reset deassertion with i_mem_read = 0, then move to RUN (or honour a redirect present in that cycle).
REQ-023 SHALL increment fetch_count by 1 on each acceptance edge, saturating at 32'hFFFFFFFF.
REQ-024 Latency: address presented in cycle N and accepted -> issue_PC/issue_valid valid in cycle N+1, aligned with memory data of fixed one-cycle latency.
REQ-025 Back-to-back acceptances with i_mem_ready held high SHALL issue one sequential address per cycle with no bubbles.

Reset
REQ-026 On reset assertion SHALL immediately (asynchronously) set PC = RESET_PC, state = BOOT, issue_PC = RESET_PC, issue_valid = 0, fetch_count = 0, i_mem_read = 0.
REQ-027 Reset asserted mid-WAIT or mid-redirect SHALL abandon the pending request; no acceptance is counted for that cycle.

Verification
REQ-028 Reset release, i_mem_ready = 1, no stall -> cycle 1 i_mem_read = 0; then addresses 0, 4, 8 on consecutive cycles; issue_PC 0, 4 with issue_valid = 1 one cycle later; fetch_count = 3 after three acceptances.
REQ-029 At PC = 8 drive i_mem_ready = 0 for 3 cycles -> address held at 8, issue_valid = 0, fetch_count frozen; ready high -> 8 accepted, next address 12.
REQ-030 At PC = 12 drive next_PC_select = 1, target_PC = 32'h00000103 -> i_mem_read = 0 that cycle, issue_valid = 0 next cycle, next address 32'h00000100.
REQ-031 stall = 1 together with next_PC_select = 1, target_PC = 32'h200 -> PC = 32'h200 after edge; stall held -> no request; stall released -> 32'h200 issued.
REQ-032 RESET_PC = 32'hFFFFFFFC, ready high -> addresses FFFFFFFC then 00000000 (wrap).
REQ-033 Assert reset asynchronously mid-cycle during WAIT -> outputs reach reset values before next clock edge; fetch_count = 0.
